// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply / restoring divide into HI/LO, with MTHI/MTLO writes
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} stateT;
    stateT state, stateNext;
    logic [CNT_W-1:0] cnt;
    logic [1:0] opReg;
    logic [WIDTH-1:0] opA, opB, absA, absB, quo, rem;
    logic [2*WIDTH:0] acc, accNext;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0] sum;
    logic [WIDTH+1:0] diff;
    logic negQ, negR, bZero, isSigned, isDiv;

    assign isSigned = !opReg[0];
    assign isDiv = opReg[1];
    assign absA = (isSigned && opA[WIDTH-1]) ? -opA : opA;
    assign absB = (isSigned && opB[WIDTH-1]) ? -opB : opB;
    // opB holds |b| during CALC; the accumulator is {upper(W+1), lower(W)}
    assign sum = acc[2*WIDTH:WIDTH] + {1'b0, opB};
    assign diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b0, opB};
    assign accNext = isDiv ? (diff[WIDTH+1] ? {acc[2*WIDTH-1:0], 1'b0}
                                            : {diff[WIDTH:0], acc[WIDTH-2:0], 1'b1})
                           : (acc[0] ? {1'b0, sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH:1]});
    assign prod = negQ ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    assign quo = negQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem = negR ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign busy = state != IDLE;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: stateNext = start ? PREP : IDLE;
            PREP: stateNext = CALC;
            CALC: stateNext = (cnt == CNT_W'(WIDTH - 1)) ? FIN : CALC;
            FIN:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            opReg <= '0;
            opA <= '0;
            opB <= '0;
            acc <= '0;
            negQ <= 1'b0;
            negR <= 1'b0;
            bZero <= 1'b0;
            hi <= '0;
            lo <= '0;
            done <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state <= stateNext;
            done <= state == FIN;
            div_by_zero <= state == FIN && bZero;
            case (state)
                IDLE: begin
                    if (start) begin
                        opReg <= op;
                        opA <= a;
                        opB <= b;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                PREP: begin
                    opB <= absB;
                    acc <= {{(WIDTH + 1){1'b0}}, absA};
                    negQ <= isSigned && (opA[WIDTH-1] ^ opB[WIDTH-1]);
                    negR <= isSigned && opA[WIDTH-1];
                    bZero <= isDiv && opB == '0;
                    cnt <= '0;
                end
                CALC: begin
                    acc <= accNext;
                    cnt <= cnt + 1'b1;
                end
                FIN: begin
                    if (!bZero) begin
                        hi <= isDiv ? rem : prod[2*WIDTH-1:WIDTH];
                        lo <= isDiv ? quo : prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
